axil_sys_ctrl: RTL and testbench

Synthesizable AXI4-Lite slave peripheral that consumes the picorv32_axi data bus for the system-control window at BASE_ADDR. It provides a byte console with an 8N1 UART transmitter behind a TX FIFO, a sticky exit-code register and a 32-bit cycle counter with reset/stop control. It sits downstream of the core's AXI-Lite master, behind the address split that routes 0x1000_0000–0x1000_000F here and everything else to RAM.

---
 rtl/axil_sys_ctrl_if.sv | 33 +++
 rtl/axil_sys_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_axil_sys_ctrl.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_sys_ctrl_if.sv
// AXI4-Lite bus bundle between the core's data master and the system-control slave.
// Signal names mirror the core's mem_axi_* bus so wiring stays one-to-one.
interface axil_sys_ctrl_if;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
           mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_rready,
    input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
           mem_axi_rvalid, mem_axi_rdata
  );

  modport slave (
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
           mem_axi_bready, mem_axi_arvalid, mem_axi_araddr, mem_axi_rready,
    output mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready,
           mem_axi_rvalid, mem_axi_rdata
  );
endinterface

// File: rtl/axil_sys_ctrl.sv
// System-control AXI4-Lite slave: UART console behind a TX FIFO, sticky exit register
// and a free-running cycle counter with reset/stop control.
module axil_sys_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           resetn,
  axil_sys_ctrl_if.slave bus,
  output logic           uart_tx,
  output logic           exit_valid,
  output logic [31:0]    exit_code
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [PW:0]   LEVEL_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic          wr_ready_reg, bvalid_reg, ar_ready_reg, rvalid_reg;
  logic [31:0]   rdata_reg, rd_mux;
  logic          wr_fire, rd_fire;
  logic [1:0]    wr_off, rd_off;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   level_reg;
  logic          overflow_reg, full, push, push_ok, pop, busy, bit_end;
  tx_state_t     state_reg;
  logic [DW-1:0] div_reg;
  logic [2:0]    bit_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg;
  logic [31:0]   cnt_reg, exit_code_reg;
  logic          run_reg, exit_valid_reg;
  logic [7:0]    level8;

  // Window selection happens in the upstream address split, so only addr[3:2] matters here.
  logic unused_ok;
  assign unused_ok = &{1'b0, BASE_ADDR, bus.mem_axi_awaddr[31:4], bus.mem_axi_awaddr[1:0],
                       bus.mem_axi_araddr[31:4], bus.mem_axi_araddr[1:0], bus.mem_axi_wstrb[3:1]};

  assign wr_off  = bus.mem_axi_awaddr[3:2];
  assign rd_off  = bus.mem_axi_araddr[3:2];
  assign wr_fire = wr_ready_reg && bus.mem_axi_awvalid && bus.mem_axi_wvalid;
  assign rd_fire = ar_ready_reg && bus.mem_axi_arvalid;
  assign push    = wr_fire && (wr_off == 2'd0) && bus.mem_axi_wstrb[0];
  assign full    = (level_reg == LEVEL_FULL);
  assign push_ok = push && !full;
  assign busy    = (state_reg != IDLE);
  assign bit_end = (div_reg == DIV_LAST);
  assign pop     = (level_reg != '0) && ((state_reg == IDLE) || (state_reg == STOP && bit_end));
  assign level8  = 8'(level_reg);

  assign bus.mem_axi_awready = wr_ready_reg;
  assign bus.mem_axi_wready  = wr_ready_reg;
  assign bus.mem_axi_bvalid  = bvalid_reg;
  assign bus.mem_axi_arready = ar_ready_reg;
  assign bus.mem_axi_rvalid  = rvalid_reg;
  assign bus.mem_axi_rdata   = rdata_reg;
  assign uart_tx    = tx_reg;
  assign exit_valid = exit_valid_reg;
  assign exit_code  = exit_code_reg;

  always_comb begin
    rd_mux = 32'd0;
    case (rd_off)
      2'd0:    rd_mux = {16'd0, level8, 5'd0, overflow_reg, busy, full};
      2'd1:    rd_mux = exit_code_reg;
      2'd2:    rd_mux = cnt_reg;
      default: rd_mux = 32'd0;
    endcase
  end

  // Ready pulses are registered single-cycle strobes; the !ready term blocks a second beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ready_reg <= 1'b0;
      bvalid_reg   <= 1'b0;
      ar_ready_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= 32'd0;
    end else begin
      wr_ready_reg <= bus.mem_axi_awvalid && bus.mem_axi_wvalid && !bvalid_reg && !wr_ready_reg;
      if (wr_fire)
        bvalid_reg <= 1'b1;
      else if (bus.mem_axi_bready)
        bvalid_reg <= 1'b0;
      ar_ready_reg <= bus.mem_axi_arvalid && !rvalid_reg && !ar_ready_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (bus.mem_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  // A stop write still applies this edge's increment, then freezes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_reg        <= 32'd0;
      run_reg        <= 1'b1;
      exit_code_reg  <= 32'd0;
      exit_valid_reg <= 1'b0;
    end else begin
      if (wr_fire && wr_off == 2'd1) begin
        exit_code_reg  <= bus.mem_axi_wdata;
        exit_valid_reg <= 1'b1;
      end
      if (wr_fire && wr_off == 2'd2 && bus.mem_axi_wdata == 32'd0) begin
        cnt_reg <= 32'd0;
        run_reg <= 1'b1;
      end else if (wr_fire && wr_off == 2'd2 && bus.mem_axi_wdata == 32'd1) begin
        if (run_reg)
          cnt_reg <= cnt_reg + 32'd1;
        run_reg <= 1'b0;
      end else if (run_reg) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr_reg] <= bus.mem_axi_wdata[7:0];
  end

  // FIFO bookkeeping and the TX FSM share one block because a pop is an FSM transition.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= IDLE;
      div_reg      <= '0;
      bit_reg      <= 3'd0;
      shift_reg    <= 8'd0;
      tx_reg       <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (push && full)
        overflow_reg <= 1'b1;
      level_reg <= level_reg + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        shift_reg  <= fifo_mem[rd_ptr_reg];
        state_reg  <= START;
        tx_reg     <= 1'b0;
        div_reg    <= '0;
      end else begin
        case (state_reg)
          IDLE: tx_reg <= 1'b1;
          START: begin
            if (bit_end) begin
              state_reg <= DATA;
              div_reg   <= '0;
              bit_reg   <= 3'd0;
              tx_reg    <= shift_reg[0];
            end else begin
              div_reg <= div_reg + DW'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              div_reg <= '0;
              if (bit_reg == 3'd7) begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end else begin
                bit_reg   <= bit_reg + 3'd1;
                shift_reg <= {1'b0, shift_reg[7:1]};
                tx_reg    <= shift_reg[1];
              end
            end else begin
              div_reg <= div_reg + DW'(1);
            end
          end
          default: begin
            if (bit_end) begin
              state_reg <= IDLE;
              div_reg   <= '0;
              tx_reg    <= 1'b1;
            end else begin
              div_reg <= div_reg + DW'(1);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axil_sys_ctrl.sv
// Directed bench for axil_sys_ctrl: two instances (CLK_DIV 4 and 16) share one bus master;
// bus handshakes are taken from instance a, UART framing is checked on both.
module tb_axil_sys_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic        m_awvalid = 1'b0, m_wvalid = 1'b0, m_bready = 1'b0, m_arvalid = 1'b0, m_rready = 1'b0;
  logic [31:0] m_awaddr = 32'd0, m_wdata = 32'd0, m_araddr = 32'd0;
  logic [3:0]  m_wstrb = 4'd0;

  logic        uart_a, uart_b, ev_a, ev_b;
  logic [31:0] ec_a, ec_b;

  axil_sys_ctrl_if bus_a ();
  axil_sys_ctrl_if bus_b ();

  assign bus_a.mem_axi_awvalid = m_awvalid;
  assign bus_a.mem_axi_awaddr  = m_awaddr;
  assign bus_a.mem_axi_wvalid  = m_wvalid;
  assign bus_a.mem_axi_wdata   = m_wdata;
  assign bus_a.mem_axi_wstrb   = m_wstrb;
  assign bus_a.mem_axi_bready  = m_bready;
  assign bus_a.mem_axi_arvalid = m_arvalid;
  assign bus_a.mem_axi_araddr  = m_araddr;
  assign bus_a.mem_axi_rready  = m_rready;
  assign bus_b.mem_axi_awvalid = m_awvalid;
  assign bus_b.mem_axi_awaddr  = m_awaddr;
  assign bus_b.mem_axi_wvalid  = m_wvalid;
  assign bus_b.mem_axi_wdata   = m_wdata;
  assign bus_b.mem_axi_wstrb   = m_wstrb;
  assign bus_b.mem_axi_bready  = m_bready;
  assign bus_b.mem_axi_arvalid = m_arvalid;
  assign bus_b.mem_axi_araddr  = m_araddr;
  assign bus_b.mem_axi_rready  = m_rready;

  axil_sys_ctrl #(.BASE_ADDR(32'h1000_0000), .CLK_DIV(4), .FIFO_DEPTH(8)) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a), .uart_tx(uart_a), .exit_valid(ev_a), .exit_code(ec_a));
  axil_sys_ctrl #(.BASE_ADDR(32'h1000_0000), .CLK_DIV(16), .FIFO_DEPTH(8)) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b), .uart_tx(uart_b), .exit_valid(ev_b), .exit_code(ec_b));

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Starts and ends on a negedge; hs is the index of the posedge that completed the handshake.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output int hs);
    int n;
    n = 0;
    hs = -1;
    m_awaddr = addr; m_wdata = data; m_wstrb = strb;
    m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b1;
    @(negedge clk);
    while (!(bus_a.mem_axi_awready && bus_a.mem_axi_wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL wr_timeout addr=%h awready=%b required 1", addr, bus_a.mem_axi_awready);
    end else begin
      hs = cyc + 1;
    end
    @(negedge clk);
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    n = 0;
    while (!bus_a.mem_axi_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, input int hold, output logic [31:0] da,
                    output logic [31:0] db, output int hs, output bit stable);
    int n;
    n = 0;
    hs = -1;
    stable = 1'b1;
    m_araddr = addr; m_arvalid = 1'b1; m_rready = 1'b0;
    @(negedge clk);
    while (!bus_a.mem_axi_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL rd_timeout addr=%h arready=%b required 1", addr, bus_a.mem_axi_arready);
    end else begin
      hs = cyc + 1;
    end
    @(negedge clk);
    m_arvalid = 1'b0;
    n = 0;
    while (!bus_a.mem_axi_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    da = bus_a.mem_axi_rdata;
    db = bus_b.mem_axi_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!(bus_a.mem_axi_rvalid && bus_a.mem_axi_rdata == da)) stable = 1'b0;
    end
    m_rready = 1'b1;
    @(negedge clk);
    m_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] da, db, v1, v2;
    int hs1, hs2;
    bit st;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_a.mem_axi_awready, bus_a.mem_axi_wready, bus_a.mem_axi_bvalid, bus_a.mem_axi_arready,
         bus_a.mem_axi_rvalid, bus_b.mem_axi_awready, bus_b.mem_axi_wready, bus_b.mem_axi_bvalid,
         bus_b.mem_axi_arready, bus_b.mem_axi_rvalid} !== 10'd0) begin
      bad++; $display("FAIL reset_handshake got=%b%b%b%b%b want=00000", bus_a.mem_axi_awready,
                      bus_a.mem_axi_wready, bus_a.mem_axi_bvalid, bus_a.mem_axi_arready, bus_a.mem_axi_rvalid);
    end
    total++;
    if ({bus_a.mem_axi_rdata, bus_b.mem_axi_rdata} !== 64'd0) begin
      bad++; $display("FAIL reset_rdata got=%h want=0", bus_a.mem_axi_rdata);
    end
    total++;
    if ({uart_a, uart_b} !== 2'b11) begin
      bad++; $display("FAIL reset_uart got=%b%b want=11", uart_a, uart_b);
    end
    total++;
    if ({ev_a, ev_b, ec_a, ec_b} !== 66'd0) begin
      bad++; $display("FAIL reset_exit got=%b/%h want=0/0", ev_a, ec_a);
    end
    resetn = 1'b1;
    @(negedge clk);
    rd(32'h1000_0000, 0, da, db, hs1, st);
    total++;
    if (da !== 32'd0) begin
      bad++; $display("FAIL reset_status got=%h want=00000000", da);
    end
    rd(32'h1000_0008, 0, v1, db, hs1, st);
    rd(32'h1000_0008, 0, v2, db, hs2, st);
    total++;
    if (v2 - v1 !== 32'(hs2 - hs1)) begin
      bad++; $display("FAIL reset_counter_running got=%0d want=%0d", v2 - v1, hs2 - hs1);
    end
    $display("test_reset done");
  endtask

  task automatic test_uart_frame();
    logic [9:0] frame;
    logic [31:0] da, db;
    int hs, n;
    bit st;
    frame = {1'b1, 8'h41, 1'b0};
    wr(32'h1000_0000, 32'h41, 4'hF, hs);
    n = 0;
    while (uart_a !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 100) begin
      bad++; $display("FAIL uart_start_timeout got=%b want=0", uart_a);
    end
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++) begin
        total++;
        if (uart_a !== frame[b]) begin
          bad++; $display("FAIL uart_bit b=%0d c=%0d got=%b want=%b", b, c, uart_a, frame[b]);
        end
        @(negedge clk);
      end
    end
    rd(32'h1000_0000, 0, da, db, hs, st);
    total++;
    if (da !== 32'd0) begin
      bad++; $display("FAIL uart_busy_after_stop got=%h want=00000000", da);
    end
    total++;
    if (db !== 32'h0000_0002) begin
      bad++; $display("FAIL uart_busy_midframe got=%h want=00000002", db);
    end
    $display("test_uart_frame done");
  endtask

  task automatic test_fifo_overflow();
    logic [7:0] rx_byte [9];
    int start_c [9];
    logic start_ok [9];
    logic stop_ok [9];
    logic [31:0] status_b, da, db;
    int hs;
    bit st, idle_ok;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    fork
      begin
        int hw, hr;
        bit s1;
        logic [31:0] xa;
        for (int k = 0; k < 10; k++) wr(32'h1000_0000, 32'h30 + 32'(k), 4'hF, hw);
        rd(32'h1000_0000, 0, xa, status_b, hr, s1);
      end
      begin
        for (int k = 0; k < 9; k++) begin
          int n;
          n = 0;
          while (uart_b !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
          end
          start_c[k] = cyc;
          repeat (8) @(negedge clk);
          start_ok[k] = (uart_b == 1'b0);
          for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            rx_byte[k][i] = uart_b;
          end
          repeat (16) @(negedge clk);
          stop_ok[k] = uart_b;
        end
      end
    join
    total++;
    if (status_b !== 32'h0000_0807) begin
      bad++; $display("FAIL fifo_full_status got=%h want=00000807", status_b);
    end
    for (int k = 0; k < 9; k++) begin
      total++;
      if ({start_ok[k], rx_byte[k], stop_ok[k]} !== {1'b1, 8'h30 + 8'(k), 1'b1}) begin
        bad++; $display("FAIL fifo_byte k=%0d got=%h start=%b stop=%b want=%h", k, rx_byte[k],
                        start_ok[k], stop_ok[k], 8'h30 + 8'(k));
      end
      if (k > 0) begin
        total++;
        if (start_c[k] - start_c[k-1] !== 160) begin
          bad++; $display("FAIL fifo_gap k=%0d got=%0d want=160", k, start_c[k] - start_c[k-1]);
        end
      end
    end
    idle_ok = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (uart_b !== 1'b1) idle_ok = 1'b0;
    end
    total++;
    if (!idle_ok) begin
      bad++; $display("FAIL fifo_tenth_dropped got=frame want=idle");
    end
    rd(32'h1000_0000, 0, da, db, hs, st);
    total++;
    if (db !== 32'h0000_0004) begin
      bad++; $display("FAIL fifo_final_status got=%h want=00000004", db);
    end
    $display("test_fifo_overflow done");
  endtask

  task automatic test_cycle_counter();
    logic [31:0] da, db, v1, v2, v3;
    int hw, hr, hs_stop, h1, h2, h3;
    bit st;
    wr(32'h1000_0008, 32'd0, 4'hF, hw);
    while (cyc < hw + 99) @(negedge clk);
    rd(32'h1000_0008, 0, da, db, hr, st);
    total++;
    if (da !== 32'(hr - hw - 1) || hr != hw + 101) begin
      bad++; $display("FAIL counter_100 got=%0d want=%0d (hs gap %0d)", da, hr - hw - 1, hr - hw);
    end
    wr(32'h1000_0008, 32'd1, 4'hF, hs_stop);
    rd(32'h1000_0008, 0, v1, db, h1, st);
    repeat (50) @(negedge clk);
    rd(32'h1000_0008, 0, v2, db, h2, st);
    total++;
    if (v1 !== 32'(hs_stop - hw)) begin
      bad++; $display("FAIL counter_stop_value got=%0d want=%0d", v1, hs_stop - hw);
    end
    total++;
    if (v2 !== v1) begin
      bad++; $display("FAIL counter_frozen got=%0d want=%0d", v2, v1);
    end
    wr(32'h1000_0008, 32'd2, 4'hF, h3);
    repeat (10) @(negedge clk);
    rd(32'h1000_0008, 0, v3, db, h3, st);
    total++;
    if (v3 !== 32'(hs_stop - hw)) begin
      bad++; $display("FAIL counter_ignored_write got=%0d want=%0d", v3, hs_stop - hw);
    end
    $display("test_cycle_counter done");
  endtask

  task automatic test_exit();
    logic [31:0] da, db;
    int hs;
    bit st;
    total++;
    if ({ev_a, ec_a} !== 33'd0) begin
      bad++; $display("FAIL exit_initial got=%b/%h want=0/0", ev_a, ec_a);
    end
    wr(32'h1000_0004, 32'd3, 4'hF, hs);
    total++;
    if ({ev_a, ec_a} !== {1'b1, 32'd3}) begin
      bad++; $display("FAIL exit_set got=%b/%h want=1/00000003", ev_a, ec_a);
    end
    rd(32'h1000_0004, 0, da, db, hs, st);
    total++;
    if (da !== 32'd3) begin
      bad++; $display("FAIL exit_read got=%h want=00000003", da);
    end
    wr(32'h1000_0004, 32'd0, 4'hF, hs);
    total++;
    if ({ev_a, ec_a} !== {1'b1, 32'd0}) begin
      bad++; $display("FAIL exit_sticky got=%b/%h want=1/00000000", ev_a, ec_a);
    end
    $display("test_exit done");
  endtask

  task automatic test_handshake();
    logic [31:0] da, db;
    int hs, n;
    bit ok, st;
    m_awaddr = 32'h1000_0004; m_wdata = 32'h55; m_wstrb = 4'hF; m_bready = 1'b1;
    ok = 1'b1;
    m_awvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.mem_axi_awready || bus_a.mem_axi_wready || bus_a.mem_axi_bvalid) ok = 1'b0;
    end
    m_awvalid = 1'b0; m_wvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.mem_axi_awready || bus_a.mem_axi_wready || bus_a.mem_axi_bvalid) ok = 1'b0;
    end
    m_wvalid = 1'b0;
    total++;
    if (!ok || ec_a !== 32'd0) begin
      bad++; $display("FAIL hs_single_channel got=accept(code %h) want=none", ec_a);
    end
    m_awvalid = 1'b1;
    repeat (3) @(negedge clk);
    wr(32'h1000_0004, 32'h55, 4'hF, hs);
    total++;
    if (ec_a !== 32'h55) begin
      bad++; $display("FAIL hs_late_w got=%h want=00000055", ec_a);
    end
    // Second write kept valid while the first response is stalled.
    m_awaddr = 32'h1000_0004; m_wdata = 32'h66; m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus_a.mem_axi_awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    m_wdata = 32'h77;
    ok = 1'b1;
    repeat (5) begin
      if (!bus_a.mem_axi_bvalid || bus_a.mem_axi_awready || bus_a.mem_axi_wready) ok = 1'b0;
      @(negedge clk);
    end
    total++;
    if (!ok || ec_a !== 32'h66) begin
      bad++; $display("FAIL hs_bready_stall got=code %h ok=%b want=code 00000066 ok=1", ec_a, ok);
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0; m_bready = 1'b1;
    @(negedge clk);
    total++;
    if (bus_a.mem_axi_bvalid !== 1'b0 || ec_a !== 32'h66) begin
      bad++; $display("FAIL hs_bready_release got=bvalid %b code %h want=0/00000066", bus_a.mem_axi_bvalid, ec_a);
    end
    wr(32'h1000_0008, 32'd0, 4'hF, hs);
    rd(32'h1000_0008, 6, da, db, hs, st);
    total++;
    if (!st) begin
      bad++; $display("FAIL hs_rdata_stable got=changed want=held %h", da);
    end
    $display("test_handshake done");
  endtask

  task automatic test_unmapped_reset();
    logic [31:0] da, db;
    int hs, n;
    bit st, idle_ok;
    rd(32'h1000_000C, 0, da, db, hs, st);
    total++;
    if ({da, db} !== 64'd0) begin
      bad++; $display("FAIL unmapped_read got=%h want=00000000", da);
    end
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    wr(32'h1000_0000, 32'h41, 4'b1110, hs);
    repeat (3) @(negedge clk);
    rd(32'h1000_0000, 0, da, db, hs, st);
    total++;
    if (da !== 32'd0) begin
      bad++; $display("FAIL strb_no_push got=%h want=00000000", da);
    end
    wr(32'h1000_0000, 32'h55, 4'hF, hs);
    wr(32'h1000_0000, 32'h66, 4'hF, hs);
    m_araddr = 32'h1000_0000; m_arvalid = 1'b1; m_rready = 1'b0;
    n = 0;
    while (!bus_a.mem_axi_rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    m_arvalid = 1'b0;
    m_awaddr = 32'h1000_0004; m_wdata = 32'd7; m_awvalid = 1'b1; m_wvalid = 1'b1; m_bready = 1'b0;
    n = 0;
    while (!bus_a.mem_axi_bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    m_awvalid = 1'b0; m_wvalid = 1'b0;
    n = 0;
    while (uart_a !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({uart_a, bus_a.mem_axi_bvalid, bus_a.mem_axi_rvalid, ev_a} !== 4'b1000) begin
      bad++; $display("FAIL midframe_reset got=tx %b bvalid %b rvalid %b exit %b want=1/0/0/0",
                      uart_a, bus_a.mem_axi_bvalid, bus_a.mem_axi_rvalid, ev_a);
    end
    resetn = 1'b1;
    m_bready = 1'b1;
    @(negedge clk);
    rd(32'h1000_0000, 0, da, db, hs, st);
    total++;
    if (da !== 32'd0) begin
      bad++; $display("FAIL reset_level got=%h want=00000000", da);
    end
    idle_ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (uart_a !== 1'b1) idle_ok = 1'b0;
    end
    total++;
    if (!idle_ok) begin
      bad++; $display("FAIL reset_fifo_dropped got=frame want=idle");
    end
    $display("test_unmapped_reset done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_uart_frame();
    test_fifo_overflow();
    test_cycle_counter();
    test_exit();
    test_handshake();
    test_unmapped_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
